cond_flag_file: RTL and testbench

//  Parametrised condition-flag file for the nRISC core; successor to the single COND bit.

---
 rtl/cond_flag_file.sv | 155 +++++++++++++++
 tb/tb_cond_flag_file.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_file.sv
//============================================================================
// Module      : cond_flag_file
// Description : Condition-flag file for the nRISC core. Holds NUM_FLAGS
//               flags written by the ULA under a per-flag mask, cleared by
//               branch consumption under a per-flag mask, with one flag
//               selectable as the branch condition. A LIFO of STACK_DEPTH
//               entries saves/restores the flag vector across calls and
//               interrupts.
// Ports       : clk, reset (sync, active-high)
//               wr_en, wr_mask, flags_in   ULA flag write
//               consume, clr_mask          branch-side flag clear
//               push, pop                  save/restore flag vector
//               cond_sel                   index of flag driven on cond_out
//               flags_out, cond_out        registered flags / selected flag
//               stack_cnt, full, empty     LIFO occupancy
//               err                        sticky over/underflow
// Config      : `define COND_STACK_ERR_EN builds the sticky error flag;
//               otherwise err is tied to 0.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module cond_flag_file #(
  parameter int                   NUM_FLAGS   = 4,
  parameter int                   STACK_DEPTH = 4,
  parameter logic [NUM_FLAGS-1:0] RESET_VALUE = '0,
  // Derived widths; not intended to be overridden.
  parameter int                   SEL_W       = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1,
  parameter int                   CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [NUM_FLAGS-1:0] wr_mask,
  input  logic [NUM_FLAGS-1:0] flags_in,
  input  logic                 consume,
  input  logic [NUM_FLAGS-1:0] clr_mask,
  input  logic                 push,
  input  logic                 pop,
  input  logic [SEL_W-1:0]     cond_sel,
  output logic [NUM_FLAGS-1:0] flags_out,
  output logic                 cond_out,
  output logic [CNT_W-1:0]     stack_cnt,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(STACK_DEPTH);

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // LIFO storage; only the pointer is reset.
  logic [NUM_FLAGS-1:0] stack_mem [STACK_DEPTH];

  logic                 mem_we;
  logic [CNT_W-1:0]     mem_addr;
  logic [NUM_FLAGS-1:0] mem_wdata;
  logic [NUM_FLAGS-1:0] stack_top;
  logic [NUM_FLAGS-1:0] flags_upd;
  logic [CNT_W-1:0]     cnt_m1;

  assign full   = (cnt_q == C_CNT_FULL);
  assign empty  = (cnt_q == '0);
  assign cnt_m1 = cnt_q - C_CNT_ONE;

  // Top-of-stack read, decoded per entry so the pointer never needs truncation.
  always_comb begin
    stack_top = '0;
    for (int e = 0; e < STACK_DEPTH; e++) begin
      if (cnt_m1 == CNT_W'(e)) stack_top = stack_mem[e];
    end
  end

  always_comb begin
    // Normal path: consume clears first, then a masked write overrides.
    flags_upd = flags_q & ~(consume ? clr_mask : '0);
    flags_upd = (flags_upd & ~(wr_en ? wr_mask : '0)) | (flags_in & (wr_en ? wr_mask : '0));

    flags_d   = flags_upd;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = cnt_q;
    mem_wdata = flags_q;

    if (pop && !empty) begin
      // Pop, or swap when push is also asserted; ULA write/consume ignored.
      flags_d = stack_top;
      if (push) begin
        mem_we   = 1'b1;
        mem_addr = cnt_m1;
      end else begin
        cnt_d = cnt_m1;
      end
    end else if (push && !pop && !full) begin
      // Save the pre-update vector; the flag update proceeds normally.
      mem_we = 1'b1;
      cnt_d  = cnt_q + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= RESET_VALUE;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < STACK_DEPTH; e++) begin
      if (mem_we && (mem_addr == CNT_W'(e))) stack_mem[e] <= mem_wdata;
    end
  end

  // Out-of-range select reads as 0.
  always_comb begin
    cond_out = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if ({{(32-SEL_W){1'b0}}, cond_sel} == 32'(i)) cond_out = flags_q[i];
    end
  end

`ifdef COND_STACK_ERR_EN
  logic err_q, err_d;
  logic overflow, underflow;

  // Push & pop together on empty counts as underflow, not overflow.
  assign overflow  = push && !pop && full;
  assign underflow = pop && empty;

  always_comb begin
    err_d = err_q | overflow | underflow;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign flags_out = flags_q;
  assign stack_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cond_flag_file.sv
//============================================================================
// Module      : tb_cond_flag_file
// Description : Directed self-checking bench for cond_flag_file
//               (NUM_FLAGS=4, STACK_DEPTH=4, RESET_VALUE=0).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_cond_flag_file;

`ifdef COND_STACK_ERR_EN
  localparam logic C_ERR_EN = 1'b1;
`else
  localparam logic C_ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_mask;
  logic [3:0] flags_in;
  logic       consume;
  logic [3:0] clr_mask;
  logic       push;
  logic       pop;
  logic [1:0] cond_sel;
  logic [3:0] flags_out;
  logic       cond_out;
  logic [2:0] stack_cnt;
  logic       full;
  logic       empty;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  cond_flag_file #(
    .NUM_FLAGS   (4),
    .STACK_DEPTH (4),
    .RESET_VALUE (4'b0000)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_mask   (wr_mask),
    .flags_in  (flags_in),
    .consume   (consume),
    .clr_mask  (clr_mask),
    .push      (push),
    .pop       (pop),
    .cond_sel  (cond_sel),
    .flags_out (flags_out),
    .cond_out  (cond_out),
    .stack_cnt (stack_cnt),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cycle(input logic we, input logic [3:0] wm, input logic [3:0] fi,
                       input logic cons, input logic [3:0] cm,
                       input logic ps, input logic pp);
    wr_en    = we;
    wr_mask  = wm;
    flags_in = fi;
    consume  = cons;
    clr_mask = cm;
    push     = ps;
    pop      = pp;
    @(posedge clk);
    #1;
    wr_en = 1'b0; consume = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [3:0] f, input logic [2:0] c,
                             input logic fu, input logic em, input logic er);
    check({tag, ".flags"}, 32'(flags_out), 32'(f));
    check({tag, ".cnt"},   32'(stack_cnt), 32'(c));
    check({tag, ".full"},  32'(full),      32'(fu));
    check({tag, ".empty"}, 32'(empty),     32'(em));
    check({tag, ".err"},   32'(err),       32'(er));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_mask = '0; flags_in = '0; consume = 1'b0;
    clr_mask = '0; push = 1'b0; pop = 1'b0; cond_sel = '0;

    // Reset state
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    check_state("reset", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;

    // Masked write
    cycle(1'b1, 4'b0101, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("mask_wr", 32'(flags_out), 32'h5);

    // cond_out follows cond_sel combinationally
    cond_sel = 2'd0; #1; check("cond0", 32'(cond_out), 32'd1);
    cond_sel = 2'd1; #1; check("cond1", 32'(cond_out), 32'd0);
    cond_sel = 2'd2; #1; check("cond2", 32'(cond_out), 32'd1);
    cond_sel = 2'd3; #1; check("cond3", 32'(cond_out), 32'd0);

    // Consume + write on the same cycle: write wins on bit 0
    cycle(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("wr_all", 32'(flags_out), 32'hF);
    cycle(1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0011, 1'b0, 1'b0);
    check("cons_wr", 32'(flags_out), 32'hD);
    cond_sel = 2'd1; #1; check("cond_after_clr", 32'(cond_out), 32'd0);

    // Push, write, pop (pop ignores write and consume)
    cycle(1'b1, 4'b1111, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("wr_1010", 32'(flags_out), 32'hA);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    check_state("push1", 4'b1010, 3'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("wr_0001", 32'(flags_out), 32'h1);
    cycle(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b0, 1'b1);
    check_state("pop1", 4'b1010, 3'd0, 1'b0, 1'b1, 1'b0);

    // Push 5 times with a concurrent write; each push saves the pre-update vector
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 4'b1111, 4'(i), 1'b0, 4'b0000, 1'b1, 1'b0);
      check($sformatf("fill%0d.cnt", i), 32'(stack_cnt), 32'(i));
      check($sformatf("fill%0d.flags", i), 32'(flags_out), 32'(i));
    end
    check("fill.full", 32'(full), 32'd1);
    check("fill.err", 32'(err), 32'd0);
    cycle(1'b1, 4'b1111, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0);
    check_state("overflow", 4'b0101, 3'd4, 1'b1, 1'b0, C_ERR_EN);

    // Pop back: saved values were 1010, 0001, 0010, 0011 (bottom to top)
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    check_state("pop_a", 4'b0011, 3'd3, 1'b0, 1'b0, C_ERR_EN);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    check("pop_b", 32'(flags_out), 32'h2);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    check_state("pop_c", 4'b0001, 3'd1, 1'b0, 1'b0, C_ERR_EN);

    // Swap: cnt=1, top=1010, flags=1100 -> flags=1010, top=1100
    cycle(1'b1, 4'b1111, 4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("pre_swap", 32'(flags_out), 32'hC);
    cycle(1'b1, 4'b1111, 4'b0110, 1'b1, 4'b1111, 1'b1, 1'b1);
    check_state("swap", 4'b1010, 3'd1, 1'b0, 1'b0, C_ERR_EN);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    check_state("pop_swapped", 4'b1100, 3'd0, 1'b0, 1'b1, C_ERR_EN);

    // Underflow: pop on empty, flags take the normal update path
    cycle(1'b1, 4'b0011, 4'b0011, 1'b1, 4'b1000, 1'b0, 1'b1);
    check_state("underflow", 4'b0111, 3'd0, 1'b0, 1'b1, C_ERR_EN);
    cycle(1'b1, 4'b1111, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b1);
    check_state("pushpop_empty", 4'b1001, 3'd0, 1'b0, 1'b1, C_ERR_EN);

    // Mid-sequence reset after 3 pushes
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("pre_reset.cnt", 32'(stack_cnt), 32'd3);
    reset = 1'b1;
    cycle(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0);
    check_state("mid_reset", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    cycle(1'b1, 4'b1000, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("post_reset_wr", 32'(flags_out), 32'h8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
